// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the round-robin bus arbiter.
// Field widths match the merged RAM/AXI bus.
package bus_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BSEL_W = 4;

    localparam logic [DATA_W-1:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    // Command captured at grant time; the bus is driven only from this copy.
    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [BSEL_W-1:0] bsel;
    } bus_cmd_t;

endpackage

// File: rtl/bus_rr_priority_picker.sv
// Combinational round-robin pick: the first requester at or above ptr, wrapping.
// Returns the winner both one-hot and as a binary index.
module rr_priority_picker #(
    parameter int N_REQ = 3,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] win_oh,
    output logic [IW-1:0]    win_idx
);

    always_comb begin : pick
        logic found;
        int   j;
        found   = 1'b0;
        j       = 0;
        win_oh  = '0;
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && req[j]) begin
                found      = 1'b1;
                win_oh[j]  = 1'b1;
                win_idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one memory/peripheral bus between N_REQ requesters.
// One transaction in flight; a bounded timeout forces an error completion.
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int                N_REQ          = 3,
    parameter int                TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_W-1:0] ERR_DATA       = DEF_ERR_DATA
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_REQ-1:0]         req_rd_i,
    input  logic [N_REQ-1:0]         req_wr_i,
    input  logic [ADDR_W*N_REQ-1:0]  req_addr_i,
    input  logic [DATA_W*N_REQ-1:0]  req_data_i,
    input  logic [BSEL_W*N_REQ-1:0]  req_byte_sel_i,
    output logic [N_REQ-1:0]         req_ready_o,
    output logic [DATA_W-1:0]        req_data_o,
    output logic                     req_err_o,
    output logic [N_REQ-1:0]         grant_o,
    output logic                     bus_rd_o,
    output logic                     bus_wr_o,
    output logic [ADDR_W-1:0]        bus_addr_o,
    output logic [DATA_W-1:0]        bus_data_o,
    output logic [BSEL_W-1:0]        bus_byte_sel_o,
    input  logic                     bus_ready_i,
    input  logic [DATA_W-1:0]        bus_data_i
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [N_REQ-1:0][ADDR_W-1:0] addr_a;
    logic [N_REQ-1:0][DATA_W-1:0] data_a;
    logic [N_REQ-1:0][BSEL_W-1:0] bsel_a;

    arb_state_e        state_q, state_d;
    logic [N_REQ-1:0]  active, win_oh, grant_q;
    logic [IW-1:0]     win_idx, ptr_q;
    bus_cmd_t          hold_q;
    logic [CW-1:0]     cnt_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q, timeout_hit, busy, done;

    assign addr_a = req_addr_i;
    assign data_a = req_data_i;
    assign bsel_a = req_byte_sel_i;
    assign active = req_rd_i | req_wr_i;

    rr_priority_picker #(.N_REQ(N_REQ), .IW(IW)) u_picker (
        .req     (active),
        .ptr     (ptr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx)
    );

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // A bus_ready_i that lands on the timeout cycle still counts as a normal completion.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|active) state_d = BUSY;
            BUSY:    if (bus_ready_i || timeout_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            grant_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (|active) begin
                    grant_q     <= win_oh;
                    ptr_q       <= (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
                    hold_q.wr   <= req_wr_i[win_idx];
                    hold_q.rd   <= req_rd_i[win_idx] & ~req_wr_i[win_idx];
                    hold_q.addr <= addr_a[win_idx];
                    hold_q.data <= data_a[win_idx];
                    hold_q.bsel <= bsel_a[win_idx];
                    cnt_q       <= '0;
                end
                BUSY: begin
                    if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                    if (bus_ready_i) begin
                        rdata_q <= bus_data_i;
                        err_q   <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata_q <= ERR_DATA;
                        err_q   <= 1'b1;
                    end
                end
                DONE: begin
                    grant_q <= '0;
                    cnt_q   <= '0;
                    err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q == BUSY);
    assign done = (state_q == DONE);

    assign bus_rd_o       = busy & hold_q.rd;
    assign bus_wr_o       = busy & hold_q.wr;
    assign bus_addr_o     = busy ? hold_q.addr : '0;
    assign bus_data_o     = busy ? hold_q.data : '0;
    assign bus_byte_sel_o = busy ? hold_q.bsel : '0;

    assign req_ready_o = done ? grant_q : '0;
    assign req_err_o   = done & err_q;
    assign req_data_o  = rdata_q;
    assign grant_o     = grant_q;

endmodule
